// File: rtl/rat_reduce.sv
// Reduces an unsigned fraction num/den to lowest terms: strip common factors of two,
// binary GCD, then two parallel restoring dividers, and a valid/ready output stage.
module rat_reduce #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_num,
  input  logic [WIDTH-1:0] in_den,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_num,
  output logic [WIDTH-1:0] out_den,
  output logic             out_err,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [2:0]       fsm_state
);

  localparam int KW = $clog2(WIDTH) + 1;
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_STRIP = 3'd1;
  localparam logic [2:0] S_GCD   = 3'd2;
  localparam logic [2:0] S_DIV   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state;
  logic [WIDTH-1:0] num_r;
  logic [WIDTH-1:0] den_r;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] g_next;
  logic             gcd_done;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] qd;
  logic [WIDTH-1:0] rn;
  logic [WIDTH-1:0] rd;
  logic [CW-1:0]    cnt;
  logic [2*WIDTH-1:0] step_n;
  logic [2*WIDTH-1:0] step_d;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; in_rdy is high only in IDLE, out_vld only in DONE, and out_* stay stable
  // from out_vld rise until the out_vld && out_rdy edge.
  assign in_rdy    = (state == S_IDLE) && rst;
  assign out_vld   = (state == S_DONE);
  assign fsm_state = state;

  assign gcd_done = (a == '0) || (b == '0);
  assign g_next   = (a | b) << k;

  // One restoring-division step; returns {remainder, quotient/dividend shift reg}.
  // Remainder stays below the divisor, so bit WIDTH of the trial difference is the borrow.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] d);
    logic [WIDTH:0] t;
    logic [WIDTH:0] s;
    t = {r, q[WIDTH-1]};
    s = t - {1'b0, d};
    if (!s[WIDTH]) begin
      div_step = {s[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
    end else begin
      div_step = {t[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
    end
  endfunction

  assign step_n = div_step(rn, qn, g);
  assign step_d = div_step(rd, qd, g);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      num_r   <= '0;
      den_r   <= '0;
      a       <= '0;
      b       <= '0;
      k       <= '0;
      g       <= '0;
      qn      <= '0;
      qd      <= '0;
      rn      <= '0;
      rd      <= '0;
      cnt     <= '0;
      out_num <= '0;
      out_den <= '0;
      out_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_vld) begin
            num_r <= in_num;
            den_r <= in_den;
            if (in_den == '0) begin
              out_num <= in_num;
              out_den <= '0;
              out_err <= 1'b1;
              state   <= S_DONE;
            end else if (in_num == '0) begin
              out_num <= '0;
              out_den <= WIDTH'(1);
              out_err <= 1'b0;
              state   <= S_DONE;
            end else begin
              a     <= in_num;
              b     <= in_den;
              k     <= '0;
              state <= S_STRIP;
            end
          end
        end

        S_STRIP: begin
          if (a[0] || b[0]) begin
            state <= S_GCD;
          end else begin
            a <= a >> 1;
            b <= b >> 1;
            k <= k + 1'b1;
          end
        end

        S_GCD: begin
          if (gcd_done) begin
            g <= g_next;
            // A gcd of one means the fraction is already reduced.
            if (g_next == WIDTH'(1)) begin
              out_num <= num_r;
              out_den <= den_r;
              out_err <= 1'b0;
              state   <= S_DONE;
            end else begin
              qn    <= num_r;
              qd    <= den_r;
              rn    <= '0;
              rd    <= '0;
              cnt   <= '0;
              state <= S_DIV;
            end
          end else if (!a[0]) begin
            a <= a >> 1;
          end else if (!b[0]) begin
            b <= b >> 1;
          end else if (a >= b) begin
            a <= (a - b) >> 1;
          end else begin
            b <= (b - a) >> 1;
          end
        end

        S_DIV: begin
          {rn, qn} <= step_n;
          {rd, qd} <= step_d;
          cnt      <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            out_num <= step_n[WIDTH-1:0];
            out_den <= step_d[WIDTH-1:0];
            out_err <= 1'b0;
            state   <= S_DONE;
          end
        end

        S_DONE: begin
          if (out_rdy) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  a_rdy_vld_excl: assert property (@(posedge clk) disable iff (!rst) !(in_rdy && out_vld));
  a_err_den_zero: assert property (@(posedge clk) disable iff (!rst) (out_vld && out_err) |-> (out_den == '0));

endmodule

// File: tb/tb_rat_reduce.sv
// Directed bench for rat_reduce: zero operands, coprime/large operands, backpressure,
// reset mid-operation and a batch of random pairs checked against a Euclid reference.
module tb_rat_reduce;

  localparam int WIDTH   = 32;
  localparam int MAX_LAT = 3 * WIDTH + 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_num;
  logic [WIDTH-1:0] in_den;
  logic             in_vld;
  logic             in_rdy;
  logic [WIDTH-1:0] out_num;
  logic [WIDTH-1:0] out_den;
  logic             out_err;
  logic             out_vld;
  logic             out_rdy;
  logic [2:0]       fsm_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*WIDTH:0] exp_q[$];

  rat_reduce #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_num   (in_num),
    .in_den   (in_den),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .out_num  (out_num),
    .out_den  (out_den),
    .out_err  (out_err),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] gcd_ref(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // driver: wait for in_rdy, present one operand pair for one accepting edge
  task automatic send(input logic [31:0] n, input logic [31:0] d);
    int w;
    w = 0;
    while (!in_rdy && w < 300) begin
      @(negedge clk);
      w++;
    end
    check_eq("in_rdy_wait", in_rdy, 1);
    in_num = n;
    in_den = d;
    in_vld = 1'b1;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    in_num = $urandom;
    in_den = $urandom;
  endtask

  // lat counts falling edges after the accepting edge until out_vld is seen
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_vld && lat < 300);
  endtask

  task automatic run_op(input logic [31:0] n, input logic [31:0] d,
                        input logic [31:0] en, input logic [31:0] ed, input logic ee,
                        input int max_lat, output int lat);
    logic [2*WIDTH:0] e;
    string tag;
    tag = $sformatf("%0d/%0d", n, d);
    exp_q.push_back({ee, en, ed});
    send(n, d);
    wait_result(lat);
    check_eq({tag, " out_vld"}, out_vld, 1);
    e = exp_q.pop_front();
    check_eq({tag, " out_num"}, out_num, e[2*WIDTH-1:WIDTH]);
    check_eq({tag, " out_den"}, out_den, e[WIDTH-1:0]);
    check_eq({tag, " out_err"}, out_err, e[2*WIDTH]);
    check_eq({tag, " latency_bound"}, lat <= max_lat, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    logic [31:0] rn;
    logic [31:0] rd;
    logic [31:0] g;

    // reset
    rst     = 1'b0;
    in_vld  = 1'b0;
    in_num  = '0;
    in_den  = '0;
    out_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst in_rdy", in_rdy, 0);
    check_eq("rst out_vld", out_vld, 0);
    check_eq("rst out_num", out_num, 0);
    check_eq("rst out_den", out_den, 0);
    check_eq("rst out_err", out_err, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("post_rst in_rdy", in_rdy, 1);

    // main function
    run_op(32'd6, 32'd8, 32'd3, 32'd4, 1'b0, MAX_LAT, lat);
    run_op(32'd1000, 32'd1000, 32'd1, 32'd1, 1'b0, MAX_LAT, lat);
    run_op(32'd0, 32'd7, 32'd0, 32'd1, 1'b0, 1, lat);
    check_eq("0/7 lat_exact", lat, 1);
    run_op(32'd5, 32'd0, 32'd5, 32'd0, 1'b1, 1, lat);
    check_eq("5/0 lat_exact", lat, 1);
    run_op(32'd17, 32'd13, 32'd17, 32'd13, 1'b0, MAX_LAT, lat);
    check_eq("17/13 div_skip", lat < WIDTH, 1);
    run_op(32'hFFFF_FFFE, 32'h8000_0000, 32'h7FFF_FFFF, 32'h4000_0000, 1'b0, MAX_LAT, lat);

    // backpressure: result held, busy-time in_vld pulse ignored
    out_rdy = 1'b0;
    run_op(32'd6, 32'd8, 32'd3, 32'd4, 1'b0, MAX_LAT, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("hold out_vld", out_vld, 1);
      check_eq("hold out_num", out_num, 3);
      check_eq("hold out_den", out_den, 4);
      check_eq("hold in_rdy", in_rdy, 0);
      if (i == 3) begin
        in_num = 32'd9;
        in_den = 32'd3;
        in_vld = 1'b1;
      end else begin
        in_vld = 1'b0;
      end
    end
    out_rdy = 1'b1;
    @(negedge clk);
    check_eq("release out_vld", out_vld, 0);
    check_eq("release in_rdy", in_rdy, 1);
    check_eq("release state", fsm_state, 0);
    run_op(32'd9, 32'd3, 32'd3, 32'd1, 1'b0, MAX_LAT, lat);

    // reset in the middle of the GCD phase
    send(32'd462, 32'd1071);
    repeat (5) @(negedge clk);
    check_eq("busy state", fsm_state, 2);
    rst = 1'b0;
    #1;
    check_eq("midrst out_vld", out_vld, 0);
    check_eq("midrst out_num", out_num, 0);
    check_eq("midrst out_den", out_den, 0);
    check_eq("midrst in_rdy", in_rdy, 0);
    check_eq("midrst state", fsm_state, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst released in_rdy", in_rdy, 1);
    run_op(32'd462, 32'd1071, 32'd22, 32'd51, 1'b0, MAX_LAT, lat);

    // random pairs in [1,1000)
    for (int i = 0; i < 20; i++) begin
      rn = $urandom_range(1, 999);
      rd = $urandom_range(1, 999);
      g  = gcd_ref(rn, rd);
      run_op(rn, rd, rn / g, rd / g, 1'b0, MAX_LAT, lat);
      check_eq("rand coprime", gcd_ref(out_num, out_den), 1);
      check_eq("rand xmul", 64'(out_num) * 64'(rd), 64'(rn) * 64'(out_den));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
